seg_scroll_sequencer: RTL and testbench
=======================================

Name: seg_scroll_sequencer

Overview:
Playback controller for the 7-segment message scroller on uo_out. Owns the symbol index and the symbol-rate prescaler. The pattern ROM is external and combinational, addressed by sym_index and returning sym_data. Adds run/pause/single-step/restart, scroll direction, an inter-loop blank gap, and PWM brightness gating on the registered segment outputs.

Parameters:
MSG_LEN, 15, number of symbols in the message (2..16)
GAP_LEN, 2, blank symbol periods inserted after each wrap (0 = no gap)
PWM_W, 4, brightness PWM counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
ena  in  1  global enable; 0 freezes all state
cfg_rate  in  8  symbol period minus 1, in clk cycles
cfg_bright  in  PWM_W  duty; 0 = off, all-ones = always on
cmd_run  in  1  level; 1 = scroll, 0 = pause
cmd_step  in  1  rising edge advances one symbol while paused
cmd_dir  in  1  0 = forward, 1 = reverse
cmd_restart  in  1  synchronous pulse; return to start of message
sym_data  in  8  pattern from external ROM for sym_index
sym_index  out  4  current ROM address
seg_out  out  8  registered, gated segment/dp drive
frame_done  out  1  one-cycle pulse on message wrap
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 GAP

Behaviour:
- Reset values:
  - sym_index = 0, seg_out = 0, frame_done = 0, state = IDLE.
  - Prescaler, gap, PWM and step-edge registers = 0.
- ena = 0: every register holds its value, including the PWM counter. No pulses are generated.
- Prescaler:
  - Counts 0..cfg_rate only in RUN or GAP; it is held at 0 in other states.
  - tick = (count == cfg_rate); the count returns to 0 on tick.
  - cfg_rate = 0 gives a tick every cycle.
  - A cfg_rate change takes effect immediately. If the count is already above the new cfg_rate, it continues and wraps at 255 before ticking.
- FSM transitions:
  - IDLE -> RUN when cmd_run = 1.
  - RUN -> PAUSE and GAP -> PAUSE when cmd_run = 0. GAP progress is discarded; PAUSE resumes into RUN at the index post-gap.
  - PAUSE -> RUN when cmd_run = 1. The prescaler restarts at 0, so the first tick comes cfg_rate+1 cycles later.
  - GAP -> RUN after GAP_LEN ticks. sym_index is then set to 0 (forward) or MSG_LEN-1 (reverse).
- Advance on tick in RUN, and on a step edge in PAUSE:
  - Forward: if sym_index == MSG_LEN-1, frame_done pulses and the block goes to GAP (or wraps straight to 0 if GAP_LEN = 0); otherwise sym_index increments.
  - Reverse: mirror image, with wrap at 0 and restart at MSG_LEN-1.
  - A step that hits the wrap skips GAP and wraps directly, still pulsing frame_done.
  - cmd_dir is sampled at each advance; a change mid-message reverses from the current index.
- cmd_step edge:
  - Detected as cmd_step & ~cmd_step_q. It is ignored outside PAUSE and ignored if cmd_run = 1 in the same cycle.
- cmd_restart (highest priority):
  - sym_index <= 0 (forward) or MSG_LEN-1 (reverse); prescaler and gap counters <= 0.
  - state <= RUN if cmd_run, else IDLE. No frame_done pulse.
- PWM:
  - Free-running PWM_W-bit counter.
  - pwm_on = (cfg_bright == all-ones) | (pwm_cnt < cfg_bright).
- seg_out:
  - Registered: seg_out <= (state ∈ {RUN, PAUSE} & pwm_on) ? sym_data : 0.
  - One-cycle latency from a sym_index change to the corresponding seg_out.
  - Blank in IDLE and GAP.
- Widths: sym_index never leaves 0..MSG_LEN-1, and frame_done is never asserted for two consecutive cycles.

Test Plan:
1. Reset mid-run: cfg_rate = 3, bright = all-ones, run = 1. After 10 cycles assert rst_n = 0 → sym_index = 0, seg_out = 0, state = IDLE immediately, with no clock needed.
2. Forward scroll: cfg_rate = 0, GAP_LEN = 2, run = 1 → sym_index 0..14, frame_done pulses one cycle at the 14→gap tick, state = GAP for 2 cycles with seg_out = 0, then index = 0 and RUN. seg_out equals the ROM value one cycle after each index.
3. Pause/step: cfg_rate = 4, run = 1 until index = 5, then run = 0. Index holds at 5 for 50 cycles. Three cmd_step rising edges (a held-high step counts once) → index = 8. run = 1 → next advance occurs exactly 5 cycles later.
4. Reverse and dir change: dir = 1 from index 0, cfg_rate = 0 → next index 14 with frame_done. Switch dir = 0 at index 10 → sequence 10, 11, 12.
5. Restart priority: cmd_restart asserted in the same cycle as a wrap tick, with run = 0 → sym_index = 0, state = IDLE, frame_done = 0.
6. Brightness: bright = 4, PWM_W = 4, run = 1, static symbol 8'h5B → seg_out = 8'h5B for 4 of every 16 cycles, else 0. bright = 0 → always 0. bright = 15 → always 8'h5B. ena = 0 freezes seg_out and all counters.

Source files
------------

// File: rtl/seg_scroll_sequencer.sv
// Playback controller for the 7-segment message scroller: symbol index, symbol-rate
// prescaler, run/pause/step/restart control, inter-loop blank gap and PWM brightness gating.
module seg_scroll_sequencer #(
   parameter int unsigned MSG_LEN = 15,
   parameter int unsigned GAP_LEN = 2,
   parameter int unsigned PWM_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [7:0]       cfg_rate,
   input  logic [PWM_W-1:0] cfg_bright,
   input  logic             cmd_run,
   input  logic             cmd_step,
   input  logic             cmd_dir,
   input  logic             cmd_restart,
   input  logic [7:0]       sym_data,
   output logic [3:0]       sym_index,
   output logic [7:0]       seg_out,
   output logic             frame_done,
   output logic [1:0]       state
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] RUN   = 2'b01;
   localparam logic [1:0] PAUSE = 2'b10;
   localparam logic [1:0] GAP   = 2'b11;

   localparam logic [3:0]        LAST_IDX = 4'(MSG_LEN - 1);
   localparam int unsigned       GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_LEN - 1);

   logic [7:0]       presc, presc_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic [PWM_W-1:0] pwm_cnt;
   logic             step_q;
   logic [1:0]       state_nxt;
   logic [3:0]       idx_nxt, start_idx, next_idx;
   logic             fd_nxt, active, tick, step_edge, at_end, pwm_on;

   assign active    = (state == RUN) || (state == GAP);
   assign tick      = active && (presc == cfg_rate);
   assign step_edge = cmd_step && !step_q && (state == PAUSE) && !cmd_run;
   assign start_idx = cmd_dir ? LAST_IDX : '0;
   assign at_end    = cmd_dir ? (sym_index == '0) : (sym_index == LAST_IDX);
   assign next_idx  = cmd_dir ? (sym_index - 4'd1) : (sym_index + 4'd1);
   assign pwm_on    = (cfg_bright == '1) || (pwm_cnt < cfg_bright);

   always_comb begin
      state_nxt = state;
      idx_nxt   = sym_index;
      gap_nxt   = gap_cnt;
      fd_nxt    = 1'b0;
      presc_nxt = tick ? '0 : (presc + 8'd1);
      if (cmd_restart) begin
         state_nxt = cmd_run ? RUN : IDLE;
         idx_nxt   = start_idx;
         gap_nxt   = '0;
         presc_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               presc_nxt = '0;
               if (cmd_run) state_nxt = RUN;
            end
            RUN: begin
               if (!cmd_run) begin
                  state_nxt = PAUSE;
                  presc_nxt = '0;
               end else if (tick) begin
                  if (at_end) begin
                     fd_nxt = 1'b1;
                     if (GAP_LEN == 0) idx_nxt = start_idx;
                     else              state_nxt = GAP;
                  end else begin
                     idx_nxt = next_idx;
                  end
               end
            end
            PAUSE: begin
               presc_nxt = '0;
               if (cmd_run) begin
                  state_nxt = RUN;
               end else if (step_edge) begin
                  // a manual step through the wrap never enters the gap
                  fd_nxt  = at_end;
                  idx_nxt = at_end ? start_idx : next_idx;
               end
            end
            GAP: begin
               if (!cmd_run) begin
                  state_nxt = PAUSE;
                  presc_nxt = '0;
                  gap_nxt   = '0;
                  idx_nxt   = start_idx;
               end else if (tick) begin
                  if (gap_cnt == GAP_LAST) begin
                     state_nxt = RUN;
                     gap_nxt   = '0;
                     idx_nxt   = start_idx;
                  end else begin
                     gap_nxt = gap_cnt + GAP_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sym_index  <= '0;
         presc      <= '0;
         gap_cnt    <= '0;
         pwm_cnt    <= '0;
         step_q     <= 1'b0;
         seg_out    <= '0;
         frame_done <= 1'b0;
      end else if (ena) begin
         state      <= state_nxt;
         sym_index  <= idx_nxt;
         presc      <= presc_nxt;
         gap_cnt    <= gap_nxt;
         pwm_cnt    <= pwm_cnt + PWM_W'(1);
         step_q     <= cmd_step;
         frame_done <= fd_nxt;
         seg_out    <= (((state == RUN) || (state == PAUSE)) && pwm_on) ? sym_data : '0;
      end else begin
         // frozen: the pulse is dropped so it can never stretch over a stall
         frame_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg_scroll_sequencer.sv
// Self-checking bench for seg_scroll_sequencer: directed sequences, a vector table and
// a randomized run against a modulo-arithmetic reference model.
module tb_seg_scroll_sequencer;

   localparam int MSG_LEN = 15;
   localparam int GAP_LEN = 2;
   localparam int PWM_W   = 4;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_GAP   = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n, ena, cmd_run, cmd_step, cmd_dir, cmd_restart;
   logic [7:0]       cfg_rate;
   logic [PWM_W-1:0] cfg_bright;
   logic [7:0]       sym_data;
   logic [3:0]       sym_index;
   logic [7:0]       seg_out;
   logic             frame_done;
   logic [1:0]       state;

   logic [7:0] rom [16];
   assign sym_data = rom[sym_index];

   seg_scroll_sequencer #(
      .MSG_LEN(MSG_LEN),
      .GAP_LEN(GAP_LEN),
      .PWM_W  (PWM_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .cfg_rate   (cfg_rate),
      .cfg_bright (cfg_bright),
      .cmd_run    (cmd_run),
      .cmd_step   (cmd_step),
      .cmd_dir    (cmd_dir),
      .cmd_restart(cmd_restart),
      .sym_data   (sym_data),
      .sym_index  (sym_index),
      .seg_out    (seg_out),
      .frame_done (frame_done),
      .state      (state)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic load_rom();
      for (int i = 0; i < 16; i++) rom[i] = 8'((i + 1) * 17);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ena = 1'b1; cmd_run = 1'b0; cmd_step = 1'b0; cmd_dir = 1'b0;
      cmd_restart = 1'b0; cfg_rate = 8'd0; cfg_bright = '1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model: the message is a ring of MSG_LEN positions; a frame ends
   // whenever a modulo step lands back on the direction's start position.
   typedef struct packed {
      logic [1:0] mode;
      int         idx;
      int         elapsed;
      int         gaps;
      logic       last_step;
      logic       frame;
      logic [7:0] seg;
      int         pwm;
   } mdl_t;

   mdl_t m;

   function automatic int start_of(input logic dir);
      return dir ? MSG_LEN - 1 : 0;
   endfunction

   function automatic mdl_t mdl_next(input mdl_t c);
      mdl_t n;
      logic active, tick, sedge, wrapped;
      int   nxt;
      n = c;
      n.frame = 1'b0;
      if (!ena) return n;
      active  = (c.mode == S_RUN) || (c.mode == S_GAP);
      tick    = active && (c.elapsed == int'(cfg_rate));
      sedge   = cmd_step && !c.last_step;
      nxt     = (c.idx + (cmd_dir ? MSG_LEN - 1 : 1)) % MSG_LEN;
      wrapped = (nxt == start_of(cmd_dir));
      n.last_step = cmd_step;
      n.pwm       = (c.pwm + 1) % (1 << PWM_W);
      n.seg       = (((c.mode == S_RUN) || (c.mode == S_PAUSE)) &&
                     ((int'(cfg_bright) == (1 << PWM_W) - 1) || (c.pwm < int'(cfg_bright))))
                    ? rom[c.idx] : 8'h00;
      n.elapsed   = (active && !tick) ? (c.elapsed + 1) % 256 : 0;
      if (cmd_restart) begin
         n.mode = cmd_run ? S_RUN : S_IDLE;
         n.idx = start_of(cmd_dir);
         n.elapsed = 0;
         n.gaps = 0;
      end else begin
         case (c.mode)
            S_IDLE: if (cmd_run) n.mode = S_RUN;
            S_RUN: begin
               if (!cmd_run) n.mode = S_PAUSE;
               else if (tick) begin
                  n.frame = wrapped;
                  if (wrapped && GAP_LEN > 0) n.mode = S_GAP;
                  else n.idx = nxt;
               end
            end
            S_PAUSE: begin
               if (cmd_run) n.mode = S_RUN;
               else if (sedge) begin
                  n.frame = wrapped;
                  n.idx = nxt;
               end
            end
            default: begin
               if (!cmd_run) begin
                  n.mode = S_PAUSE;
                  n.gaps = 0;
                  n.idx = start_of(cmd_dir);
               end else if (tick) begin
                  n.gaps = c.gaps + 1;
                  if (n.gaps == GAP_LEN) begin
                     n.mode = S_RUN;
                     n.gaps = 0;
                     n.idx = start_of(cmd_dir);
                  end
               end
            end
         endcase
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= mdl_next(m);
   end

   typedef struct {
      logic       run;
      logic [3:0] idx;
      logic [1:0] st;
      logic       fd;
      logic [7:0] seg;
   } vec_t;

   vec_t tbl [19];
   logic [7:0] pat [16];
   int n, ones;

   initial begin
      load_rom();
      // forward scroll with rate 0: row e holds the outputs after clock edge e+1
      for (int e = 1; e <= 19; e++) begin
         tbl[e-1].run = 1'b1;
         tbl[e-1].fd  = 1'b0;
         tbl[e-1].st  = S_RUN;
         tbl[e-1].idx = 4'(e - 1);
         tbl[e-1].seg = (e >= 2) ? rom[e-2] : 8'h00;
      end
      tbl[15] = '{1'b1, 4'd14, S_GAP, 1'b1, rom[14]};
      tbl[16] = '{1'b1, 4'd14, S_GAP, 1'b0, 8'h00};
      tbl[17] = '{1'b1, 4'd0,  S_RUN, 1'b0, 8'h00};
      tbl[18] = '{1'b1, 4'd1,  S_RUN, 1'b0, rom[0]};

      rst_n = 1'b0; ena = 1'b1; cmd_run = 1'b0; cmd_step = 1'b0; cmd_dir = 1'b0;
      cmd_restart = 1'b0; cfg_rate = 8'd0; cfg_bright = '1;
      @(negedge clk);
      @(negedge clk);
      check("rst_idx", sym_index, 0);
      check("rst_seg", seg_out, 0);
      check("rst_fd", frame_done, 0);
      check("rst_state", state, S_IDLE);
      rst_n = 1'b1;
      cyc(3);
      check("idle_hold", state, S_IDLE);

      // asynchronous reset in the middle of a run
      do_reset();
      cfg_rate = 8'd3; cmd_run = 1'b1;
      cyc(10);
      check("mid_state", state, S_RUN);
      check("mid_idx", sym_index, 2);
      check("mid_seg", seg_out, rom[2]);
      #2 rst_n = 1'b0;
      #1;
      check("async_idx", sym_index, 0);
      check("async_seg", seg_out, 0);
      check("async_state", state, S_IDLE);
      @(negedge clk);
      rst_n = 1'b1;

      // forward scroll through the gap, table driven
      do_reset();
      for (int r = 0; r < 19; r++) begin
         cmd_run = tbl[r].run;
         cyc();
         check($sformatf("fwd_idx[%0d]", r), sym_index, tbl[r].idx);
         check($sformatf("fwd_state[%0d]", r), state, tbl[r].st);
         check($sformatf("fwd_fd[%0d]", r), frame_done, tbl[r].fd);
         check($sformatf("fwd_seg[%0d]", r), seg_out, tbl[r].seg);
      end

      // pause, single steps, resume latency
      do_reset();
      cfg_rate = 8'd4; cmd_run = 1'b1;
      for (int i = 0; i < 100 && sym_index != 4'd5; i++) cyc();
      check("reach5", sym_index, 5);
      cmd_run = 1'b0;
      cyc(50);
      check("pause_idx", sym_index, 5);
      check("pause_state", state, S_PAUSE);
      cmd_step = 1'b1; cyc(2);
      cmd_step = 1'b0; cyc();
      cmd_step = 1'b1; cyc();
      cmd_step = 1'b0; cyc();
      cmd_step = 1'b1; cyc();
      cmd_step = 1'b0; cyc();
      check("step_idx", sym_index, 8);
      check("step_seg", seg_out, rom[8]);
      cmd_run = 1'b1;
      cyc();
      check("resume_state", state, S_RUN);
      n = 0;
      while (sym_index == 4'd8 && n < 20) begin
         cyc();
         n++;
      end
      check("resume_lat", n, 5);
      check("resume_idx", sym_index, 9);

      // reverse wrap through the gap, then direction change
      do_reset();
      cmd_run = 1'b1; cmd_dir = 1'b1;
      cyc(2);
      check("rev_fd", frame_done, 1);
      check("rev_gap", state, S_GAP);
      cyc(2);
      check("rev_idx14", sym_index, 14);
      check("rev_run", state, S_RUN);
      cyc(4);
      check("rev_idx10", sym_index, 10);
      cmd_dir = 1'b0;
      cyc();
      check("dir_idx11", sym_index, 11);
      cyc();
      check("dir_idx12", sym_index, 12);

      // restart against a wrap tick
      do_reset();
      cmd_run = 1'b1;
      cyc(15);
      check("pre_wrap_idx", sym_index, 14);
      cmd_restart = 1'b1; cmd_run = 1'b0;
      cyc();
      check("rs_idx", sym_index, 0);
      check("rs_state", state, S_IDLE);
      check("rs_fd", frame_done, 0);
      cmd_dir = 1'b1; cmd_run = 1'b1;
      cyc();
      check("rs_rev_idx", sym_index, 14);
      check("rs_rev_state", state, S_RUN);
      cmd_restart = 1'b0;

      // brightness and enable freeze
      do_reset();
      for (int i = 0; i < 16; i++) rom[i] = 8'h5B;
      cfg_rate = 8'd255; cfg_bright = 4'd4; cmd_run = 1'b1;
      cyc(3);
      ones = 0;
      for (int j = 0; j < 16; j++) begin
         cyc();
         pat[j] = seg_out;
         if (seg_out == 8'h5B) ones++;
      end
      check("bright4_on", ones, 4);
      n = 0;
      for (int j = 0; j < 16; j++) if (pat[j] == 8'h00) n++;
      check("bright4_off", n, 12);
      ena = 1'b0;
      for (int j = 0; j < 7; j++) begin
         cyc();
         check("freeze_seg", seg_out, pat[15]);
      end
      ena = 1'b1;
      for (int j = 0; j < 16; j++) begin
         cyc();
         check("pwm_phase", seg_out, pat[j]);
      end
      check("freeze_idx", sym_index, 0);
      cfg_bright = 4'd0;
      ones = 0;
      for (int j = 0; j < 16; j++) begin
         cyc();
         if (seg_out != 8'h00) ones++;
      end
      check("bright0", ones, 0);
      cfg_bright = 4'd15;
      ones = 0;
      for (int j = 0; j < 16; j++) begin
         cyc();
         if (seg_out == 8'h5B) ones++;
      end
      check("bright15", ones, 16);

      // randomized run against the reference model
      load_rom();
      do_reset();
      cmd_run = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         ena = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 24) == 0) cmd_run = ~cmd_run;
         cmd_step = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 39) == 0) cmd_dir = ~cmd_dir;
         cmd_restart = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 39) == 0) cfg_rate = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 399) == 0) cfg_rate = 8'd40;
         if ($urandom_range(0, 29) == 0) cfg_bright = 4'($urandom_range(0, 15));
         cyc();
         check("rand", {17'd0, sym_index, seg_out, frame_done, state},
               {17'd0, 4'(m.idx), m.seg, m.frame, m.mode});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
